// File: rtl/bf_program_loader_if.sv
// Byte-stream and instruction-memory write bus of the brainfuck program loader.
// The master side feeds ASCII text and observes the writes; the loader is the slave.
interface bf_program_loader_if #(
  parameter int ADDR_W = 16
);
  logic              char_valid_in;
  logic [7:0]        char_data_in;
  logic              char_ready_out;
  logic              instr_we_out;
  logic [ADDR_W-1:0] instr_addr_out;
  logic [2:0]        instr_data_out;

  modport master (
    output char_valid_in, char_data_in,
    input  char_ready_out, instr_we_out, instr_addr_out, instr_data_out
  );

  modport slave (
    input  char_valid_in, char_data_in,
    output char_ready_out, instr_we_out, instr_addr_out, instr_data_out
  );
endinterface

// File: rtl/bf_program_loader.sv
// Filters brainfuck source text into 3-bit opcodes, writes them to instruction memory
// from address 0, and checks bracket balance, nesting depth and program length.
module bf_program_loader #(
  parameter int ADDR_W  = 16,
  parameter int DEPTH_W = 8
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                start_in,
  bf_program_loader_if.slave  bus,
  output logic                busy_out,
  output logic                done_out,
  output logic                error_out,
  output logic [2:0]          error_code_out,
  output logic [ADDR_W:0]     prog_len_out
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_UNMATCHED = 3'd1,
    ERR_UNCLOSED  = 3'd2,
    ERR_DEPTH     = 3'd3,
    ERR_LENGTH    = 3'd4
  } err_t;

  localparam logic [7:0]         CHAR_OPEN  = 8'h5B;
  localparam logic [7:0]         CHAR_CLOSE = 8'h5D;
  localparam logic [ADDR_W:0]    LEN_ONE    = 1;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = 1;

  state_t             state, state_next;
  err_t               err_next;
  logic               write_en;
  logic               is_cmd;
  logic [2:0]         opcode;
  logic [DEPTH_W-1:0] depth;
  logic               accept;

  assign accept = bus.char_ready_out && bus.char_valid_in;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, otherwise the
    // unlisted case arms would infer latches.
    is_cmd = 1'b1;
    opcode = 3'd0;
    case (bus.char_data_in)
      8'h2B:      opcode = 3'd0;
      8'h2D:      opcode = 3'd1;
      8'h3E:      opcode = 3'd2;
      8'h3C:      opcode = 3'd3;
      CHAR_OPEN:  opcode = 3'd4;
      CHAR_CLOSE: opcode = 3'd5;
      8'h2E:      opcode = 3'd6;
      8'h2C:      opcode = 3'd7;
      default:    is_cmd = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  // A full count (top bit of prog_len set) means capacity is exhausted.
  always_comb begin
    state_next = state;
    err_next   = ERR_NONE;
    write_en   = 1'b0;
    case (state)
      LOAD: begin
        if (accept) begin
          if (bus.char_data_in == 8'h00) begin
            if (depth != '0) begin
              state_next = ERROR;
              err_next   = ERR_UNCLOSED;
            end else begin
              state_next = DONE;
            end
          end else if (is_cmd) begin
            if (prog_len_out[ADDR_W]) begin
              state_next = ERROR;
              err_next   = ERR_LENGTH;
            end else if (bus.char_data_in == CHAR_CLOSE && depth == '0) begin
              state_next = ERROR;
              err_next   = ERR_UNMATCHED;
            end else if (bus.char_data_in == CHAR_OPEN && depth == '1) begin
              state_next = ERROR;
              err_next   = ERR_DEPTH;
            end else begin
              write_en = 1'b1;
            end
          end
        end
      end
      default: begin
        if (start_in) state_next = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      bus.char_ready_out  <= 1'b0;
      bus.instr_we_out    <= 1'b0;
      bus.instr_addr_out  <= '0;
      bus.instr_data_out  <= 3'd0;
      busy_out            <= 1'b0;
      done_out            <= 1'b0;
      error_out           <= 1'b0;
      error_code_out      <= ERR_NONE;
      prog_len_out        <= '0;
      depth               <= '0;
    end else begin
      bus.char_ready_out <= (state_next == LOAD);
      busy_out           <= (state_next == LOAD);
      done_out           <= (state_next == DONE);
      error_out          <= (state_next == ERROR);
      bus.instr_we_out   <= write_en;

      if (state != LOAD && start_in) begin
        prog_len_out   <= '0;
        depth          <= '0;
        error_code_out <= ERR_NONE;
      end

      if (write_en) begin
        bus.instr_addr_out <= prog_len_out[ADDR_W-1:0];
        bus.instr_data_out <= opcode;
        prog_len_out       <= prog_len_out + LEN_ONE;
        if (bus.char_data_in == CHAR_OPEN)       depth <= depth + DEPTH_ONE;
        else if (bus.char_data_in == CHAR_CLOSE) depth <= depth - DEPTH_ONE;
      end

      if (state == LOAD && state_next == ERROR) error_code_out <= err_next;
    end
  end

endmodule

// File: tb/tb_bf_program_loader.sv
// Directed bench for bf_program_loader: a default-sized instance and a small one
// (ADDR_W=2, DEPTH_W=2) for the capacity and nesting limits.
module tb_bf_program_loader;

  typedef struct {
    logic [15:0] addr;
    logic [2:0]  op;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic sel = 1'b0;

  int checks = 0;
  int errors = 0;
  wr_t wlog[$];

  always #5 clk = ~clk;

  bf_program_loader_if #(.ADDR_W(16)) bus_a ();
  bf_program_loader_if #(.ADDR_W(2))  bus_b ();

  logic        busy_a, done_a, error_a, busy_b, done_b, error_b;
  logic [2:0]  code_a, code_b;
  logic [16:0] len_a;
  logic [2:0]  len_b;

  assign bus_a.char_valid_in = valid && !sel;
  assign bus_a.char_data_in  = data;
  assign bus_b.char_valid_in = valid && sel;
  assign bus_b.char_data_in  = data;

  bf_program_loader #(.ADDR_W(16), .DEPTH_W(8)) dut_a (
    .clk_in(clk), .reset_in(reset), .start_in(start && !sel), .bus(bus_a.slave),
    .busy_out(busy_a), .done_out(done_a), .error_out(error_a),
    .error_code_out(code_a), .prog_len_out(len_a)
  );

  bf_program_loader #(.ADDR_W(2), .DEPTH_W(2)) dut_b (
    .clk_in(clk), .reset_in(reset), .start_in(start && sel), .bus(bus_b.slave),
    .busy_out(busy_b), .done_out(done_b), .error_out(error_b),
    .error_code_out(code_b), .prog_len_out(len_b)
  );

  logic        m_ready, m_we, m_busy, m_done, m_error;
  logic [2:0]  m_code, m_data;
  logic [15:0] m_addr;
  logic [16:0] m_len;
  logic [24:0] m_status;

  assign m_ready  = sel ? bus_b.char_ready_out : bus_a.char_ready_out;
  assign m_we     = sel ? bus_b.instr_we_out : bus_a.instr_we_out;
  assign m_addr   = sel ? {14'd0, bus_b.instr_addr_out} : bus_a.instr_addr_out;
  assign m_data   = sel ? bus_b.instr_data_out : bus_a.instr_data_out;
  assign m_busy   = sel ? busy_b : busy_a;
  assign m_done   = sel ? done_b : done_a;
  assign m_error  = sel ? error_b : error_a;
  assign m_code   = sel ? code_b : code_a;
  assign m_len    = sel ? {14'd0, len_b} : len_a;
  // {busy, ready, we, done, error, code[2:0], len[16:0]}
  assign m_status = {m_busy, m_ready, m_we, m_done, m_error, m_code, m_len};

  always @(negedge clk) begin
    wr_t w;
    if (m_we) begin
      w.addr = m_addr;
      w.op   = m_data;
      wlog.push_back(w);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input string name);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    wlog.delete();
    checks++;
    if (m_status !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 17'd0}) begin
      errors++;
      $display("FAIL %s_start status got %h want %h", name, m_status,
               {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 17'd0});
    end
  endtask

  task automatic send_stream(input string s, input bit nul, input int gap);
    int n;
    int w;
    n = s.len() + (nul ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      data  = (i < s.len()) ? s[i] : 8'h00;
      valid = 1'b1;
      w = 0;
      while (!m_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!m_ready) begin
        checks++;
        errors++;
        $display("FAIL send_timeout byte %0d ready got 0 want 1", i);
        valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      if (gap > 0 && i < n - 1) begin
        valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if (m_status !== 25'd0 || m_addr !== 16'd0 || m_data !== 3'd0) begin
      errors++;
      $display("FAIL reset_state status got %h/%h/%h want 0/0/0", m_status, m_addr, m_data);
    end
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    #1;
    checks++;
    if (m_status !== 25'd0) begin
      errors++;
      $display("FAIL reset_over_start status got %h want 0", m_status);
    end
  endtask

  task automatic test_basic;
    string exp_ops = "04120356";
    do_start("basic");
    send_stream("+[->+<].", 1'b1, 0);
    checks++;
    if (m_status !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 17'd8}) begin
      errors++;
      $display("FAIL basic_status got %h want %h", m_status,
               {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 17'd8});
    end
    checks++;
    if (wlog.size() != exp_ops.len()) begin
      errors++;
      $display("FAIL basic_writes got %0d want %0d", wlog.size(), exp_ops.len());
    end
    for (int i = 0; i < exp_ops.len() && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i].addr !== 16'(i) || wlog[i].op !== 3'(exp_ops[i] - 8'h30)) begin
        errors++;
        $display("FAIL basic_write%0d got (%0d,%0d) want (%0d,%0d)", i, wlog[i].addr,
                 wlog[i].op, i, exp_ops[i] - 8'h30);
      end
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (m_done !== 1'b1 || m_len !== 17'd8) begin
      errors++;
      $display("FAIL basic_held done/len got %b/%0d want 1/8", m_done, m_len);
    end
  endtask

  task automatic test_comment_filter;
    do_start("comment");
    send_stream("a+ b\n-", 1'b1, 1);
    checks++;
    if (m_status !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 17'd2}) begin
      errors++;
      $display("FAIL comment_status got %h want %h", m_status,
               {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 17'd2});
    end
    checks++;
    if (wlog.size() != 2) begin
      errors++;
      $display("FAIL comment_writes got %0d want 2", wlog.size());
    end else begin
      checks++;
      if (wlog[0].addr !== 16'd0 || wlog[0].op !== 3'd0 ||
          wlog[1].addr !== 16'd1 || wlog[1].op !== 3'd1) begin
        errors++;
        $display("FAIL comment_pairs got (%0d,%0d)(%0d,%0d) want (0,0)(1,1)",
                 wlog[0].addr, wlog[0].op, wlog[1].addr, wlog[1].op);
      end
    end
  endtask

  task automatic test_error(input string name, input string s, input bit nul,
                            input string exp_ops, input logic [2:0] code);
    do_start(name);
    send_stream(s, nul, 0);
    checks++;
    if (m_status !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, code, 17'(exp_ops.len())}) begin
      errors++;
      $display("FAIL %s_status got %h want %h", name, m_status,
               {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, code, 17'(exp_ops.len())});
    end
    checks++;
    if (wlog.size() != exp_ops.len()) begin
      errors++;
      $display("FAIL %s_writes got %0d want %0d", name, wlog.size(), exp_ops.len());
    end
    for (int i = 0; i < exp_ops.len() && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i].addr !== 16'(i) || wlog[i].op !== 3'(exp_ops[i] - 8'h30)) begin
        errors++;
        $display("FAIL %s_write%0d got (%0d,%0d) want (%0d,%0d)", name, i, wlog[i].addr,
                 wlog[i].op, i, exp_ops[i] - 8'h30);
      end
    end
  endtask

  task automatic test_reset_restart;
    do_start("midload");
    send_stream("+++", 1'b0, 0);
    checks++;
    if (m_we !== 1'b1 || m_len !== 17'd3) begin
      errors++;
      $display("FAIL midload_pending we/len got %b/%0d want 1/3", m_we, m_len);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (m_status !== 25'd0 || m_addr !== 16'd0 || m_data !== 3'd0) begin
      errors++;
      $display("FAIL midload_reset status got %h/%h/%h want 0/0/0", m_status, m_addr, m_data);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (m_status !== 25'd0) begin
      errors++;
      $display("FAIL midload_idle status got %h want 0", m_status);
    end

    do_start("restart");
    send_stream(".", 1'b1, 0);
    checks++;
    if (m_status !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 17'd1} || wlog.size() != 1) begin
      errors++;
      $display("FAIL restart_status got %h/%0d want %h/1", m_status, wlog.size(),
               {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 17'd1});
    end else begin
      checks++;
      if (wlog[0].addr !== 16'd0 || wlog[0].op !== 3'd6) begin
        errors++;
        $display("FAIL restart_write got (%0d,%0d) want (0,6)", wlog[0].addr, wlog[0].op);
      end
    end

    do_start("empty");
    send_stream("", 1'b1, 0);
    checks++;
    if (m_status !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 17'd0} || wlog.size() != 0) begin
      errors++;
      $display("FAIL empty_status got %h/%0d want %h/0", m_status, wlog.size(),
               {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 17'd0});
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_comment_filter();
    test_error("unmatched", "+]", 1'b0, "0", 3'd1);
    test_error("unclosed", "[[+]", 1'b1, "4405", 3'd2);
    sel = 1'b1;
    @(negedge clk);
    #1;
    test_error("depth", "[[[[", 1'b0, "444", 3'd3);
    test_error("capacity", "+++++", 1'b0, "0000", 3'd4);
    sel = 1'b0;
    @(negedge clk);
    #1;
    test_reset_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
